ndrot_bank: RTL and testbench
=============================

// Module: ndrot_bank
// PURPOSE
// - NCH-channel, cycle-based behavioural model of an RSFQ non-destructive-readout-with-toggle (NDROT) register bank, for fast system sims.
// - Per channel: 'a' pulse sets the stored bit, 'b' pulse clears it.
// - A shared 'rd' pulse reads all channels without disturbing them; each set channel emits one output pulse.
// - Adds hold-window violation flags, a readout-rate check, a power-up settle period and a selectable output encoding.
// PARAMETERS
// - NCH          4  number of channels
// - DELAY        2  rd-to-q latency in clk cycles, >=1
// - INIT_CYCLES  4  cycles after reset release before pulses are honoured
// - HOLD_AB      1  cycles after a set during which a 'b' pulse is a violation
// - HOLD_BA      1  cycles after a clear during which an 'a' pulse is a violation
// - RD_GAP       3  minimum cycles between rd pulses while any channel is set
// - OUT_MODE     0  0 = toggle-encoded q (level flips per pulse), 1 = q high for one cycle per pulse
// PORTS
// - clk      in   1    system clock, all logic on rising edge
// - rst_n    in   1    synchronous reset, active low
// - a        in   NCH  per-channel set lines, toggle-encoded (each level change = 1 pulse)
// - b        in   NCH  per-channel clear lines, toggle-encoded
// - rd       in   1    shared readout line, toggle-encoded
// - q        out  NCH  per-channel output pulses, encoding per OUT_MODE
// - state    out  NCH  stored bit per channel, debug visibility
// - ready    out  1    high once the INIT_CYCLES settle period has elapsed
// - viol_ab  out  NCH  sticky: 'b' arrived inside the HOLD_AB window, or together with 'a'
// - viol_ba  out  NCH  sticky: 'a' arrived inside the HOLD_BA window
// - viol_rd  out  1    sticky: rd pulse spacing below RD_GAP while any channel set
// BEHAVIOUR
// - One clock (clk); reset synchronous, active-low (rst_n).
// - Reset (rst_n=0 at a clk edge):
//   - state, q, ready, all viol_* and the delay pipeline go to 0; counters clear.
//   - Edge-detect registers load the current a/b/rd levels, so no spurious pulse on release.
// - Pulse detect: pulse = input level differs from the previous sampled level. At most one pulse per line per cycle.
// - Settle: counter runs from reset release; ready=1 on the INIT_CYCLES-th edge after release.
//   - While ready=0: pulses are consumed by edge detect but ignored; no state change, no flags.
// - Channel FSM, states CLR(0) and SET(1):
//   - CLR + a -> SET.  SET + a -> SET (no change).
//   - SET + b -> CLR.  CLR + b -> CLR (no change).
//   - a and b in the same cycle: final state CLR, viol_ab set.
// - Hold checks (per channel; counters start at the transition, window = HOLD_* cycles after it):
//   - 'b' within HOLD_AB cycles after CLR->SET: set viol_ab; the clear still applies.
//   - 'a' within HOLD_BA cycles after SET->CLR: set viol_ba; the set still applies.
// - Readout:
//   - An rd pulse samples state as it was before this cycle's a/b updates.
//   - Every channel with sampled state=1 issues an output event exactly DELAY cycles later.
//   - State is never altered by rd.
//   - Output event: OUT_MODE 0 inverts q[i]; OUT_MODE 1 drives q[i]=1 for one cycle, 0 otherwise.
//   - Back-to-back rd pulses pipeline: one event per rd, none merged or dropped.
// - rd gap: cycles since the last honoured rd < RD_GAP and any state bit = 1 -> viol_rd. The rd is still processed.
// - Counters saturate; widths are $clog2(max+1).
// - Viol flags clear only on reset.
// STRUCTURE
// - Package ndrot_pkg: ndrot_state_e {CLR, SET}, out-mode localparams, function cnt_w(max).
// - Sub-module ndrot_cell (one channel):
//   - FSM, hold counters, viol_ab/viol_ba, per-channel DELAY shift stage and output encoder.
//   - Instantiated NCH times via generate.
// - The top holds edge detect, the settle counter, the shared rd-gap counter and viol_rd.
// TESTING
// - Reset release, toggle a[0] at cycle 6 (ready=1) then rd at cycle 10 -> state[0]=1; q[0] flips at cycle 12 (DELAY=2); other q unchanged.
// - a[1] toggled at cycle 2 (ready=0) -> state[1] stays 0; no flags; rd gives no q[1] event.
// - a[2] at cycle 8 and b[2] at cycle 9 -> state[2]=0 at 10, viol_ab[2]=1. Same test with b at cycle 11 -> viol_ab[2]=0.
// - a[3] and b[3] in the same cycle from CLR -> state[3]=0, viol_ab[3]=1.
// - ch0 set, rd at cycles 10 and 11 -> two q[0] events at 12 and 13, viol_rd=1. Same with all channels CLR -> no q events, viol_rd=0.
// - OUT_MODE=1, ch0 set, rd at cycle 10 -> q[0]=1 during cycle 12 only. rst_n=0 at cycle 11 -> no event at 12; all outputs 0.

Source files
------------

// File: rtl/ndrot_pkg.sv
// -----------------------------------------------------------------------------
// ndrot_pkg
// Shared types and helpers for the NDROT register bank model.
//   ndrot_state_e : stored-bit state of one channel (CLR / SET)
//   OUT_TOGGLE    : q flips level once per output event
//   OUT_PULSE     : q is high for exactly one cycle per output event
//   cnt_w(max)    : width of a counter that must hold 0..max (never below 1)
// -----------------------------------------------------------------------------
package ndrot_pkg;

    typedef enum logic {
        CLR = 1'b0,
        SET = 1'b1
    } ndrot_state_e;

    localparam int OUT_TOGGLE = 0;
    localparam int OUT_PULSE  = 1;

    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/ndrot_bank_if.sv
// -----------------------------------------------------------------------------
// ndrot_bank_if
// Signal bundle of the NDROT bank.
//   a, b    : per-channel set / clear lines, toggle-encoded
//   rd      : shared readout line, toggle-encoded
//   q       : per-channel output events (encoding chosen by OUT_MODE)
//   state   : stored bit per channel (debug view of the channel FSMs)
//   ready   : settle period elapsed
//   viol_*  : sticky timing-violation flags
// master = stimulus side, slave = the bank.
// -----------------------------------------------------------------------------
interface ndrot_bank_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] a;
    logic [NCH-1:0] b;
    logic           rd;
    logic [NCH-1:0] q;
    logic [NCH-1:0] state;
    logic           ready;
    logic [NCH-1:0] viol_ab;
    logic [NCH-1:0] viol_ba;
    logic           viol_rd;

    modport master (
        output a, b, rd,
        input  q, state, ready, viol_ab, viol_ba, viol_rd
    );

    modport slave (
        input  a, b, rd,
        output q, state, ready, viol_ab, viol_ba, viol_rd
    );
endinterface

// File: rtl/ndrot_cell.sv
// -----------------------------------------------------------------------------
// ndrot_cell
// One NDROT channel: CLR/SET FSM, hold-window checks, readout delay line and
// output encoder. All pulse inputs arrive already edge-detected and gated by
// the bank's ready signal.
//   clk, rst_n : clock, synchronous active-low reset
//   a_p, b_p   : set / clear pulse this cycle
//   rd_p       : readout pulse this cycle
//   st         : stored bit
//   q          : output (toggle or one-cycle pulse per event)
//   viol_ab    : sticky, clear too soon after set (or together with set)
//   viol_ba    : sticky, set too soon after clear
// -----------------------------------------------------------------------------
module ndrot_cell
    import ndrot_pkg::*;
#(
    parameter int DELAY    = 2,
    parameter int HOLD_AB  = 1,
    parameter int HOLD_BA  = 1,
    parameter int OUT_MODE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_p,
    input  logic b_p,
    input  logic rd_p,
    output logic st,
    output logic q,
    output logic viol_ab,
    output logic viol_ba
);
    localparam int AB_W = cnt_w(HOLD_AB);
    localparam int BA_W = cnt_w(HOLD_BA);

    ndrot_state_e   st_q, st_d;
    // Remaining cycles of each hold window; zero means no window open.
    logic [AB_W-1:0] win_ab_q, win_ab_d;
    logic [BA_W-1:0] win_ba_q, win_ba_d;
    logic            ab_hit, ba_hit;
    logic [DELAY-1:0] pipe_q;
    logic            ev;

    always_comb begin
        st_d     = st_q;
        win_ab_d = (win_ab_q != '0) ? win_ab_q - AB_W'(1) : '0;
        win_ba_d = (win_ba_q != '0) ? win_ba_q - BA_W'(1) : '0;
        ab_hit   = 1'b0;
        ba_hit   = 1'b0;

        // Simultaneous set and clear resolves to CLR and is itself a violation.
        if (a_p && b_p) begin
            st_d   = CLR;
            ab_hit = 1'b1;
        end else if (a_p) begin
            st_d = SET;
        end else if (b_p) begin
            st_d = CLR;
        end

        if (b_p && (win_ab_q != '0)) ab_hit = 1'b1;
        if (a_p && (win_ba_q != '0)) ba_hit = 1'b1;

        // Windows open only on a real transition, not on a redundant pulse.
        if (st_q == CLR && st_d == SET) win_ab_d = AB_W'(HOLD_AB);
        if (st_q == SET && st_d == CLR) win_ba_d = BA_W'(HOLD_BA);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q     <= CLR;
            win_ab_q <= '0;
            win_ba_q <= '0;
            viol_ab  <= 1'b0;
            viol_ba  <= 1'b0;
        end else begin
            st_q     <= st_d;
            win_ab_q <= win_ab_d;
            win_ba_q <= win_ba_d;
            if (ab_hit) viol_ab <= 1'b1;
            if (ba_hit) viol_ba <= 1'b1;
        end
    end

    // Readout samples the pre-update state; one stage per cycle of latency so
    // back-to-back reads stay separate events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= rd_p && (st_q == SET);
            for (int i = 1; i < DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign ev = pipe_q[DELAY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (OUT_MODE == OUT_PULSE) begin
            q <= ev;
        end else begin
            q <= q ^ ev;
        end
    end

    assign st = (st_q == SET);

endmodule

// File: rtl/ndrot_bank.sv
// -----------------------------------------------------------------------------
// ndrot_bank
// NCH-channel cycle-based model of an RSFQ NDROT register bank.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ndrot_bank_if slave (a, b, rd in; q, state, ready, viol_* out)
// Holds edge detection, the power-up settle counter and the shared readout
// spacing check; per-channel behaviour lives in ndrot_cell.
//
// Interface protocol: there is no valid/ready handshake. Each input line is a
// toggle-encoded pulse stream (a level change = one pulse), consumed in the
// cycle it changes; ready is a status output, not backpressure, and pulses
// seen while it is low are discarded.
// -----------------------------------------------------------------------------
module ndrot_bank
    import ndrot_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DELAY       = 2,
    parameter int INIT_CYCLES = 4,
    parameter int HOLD_AB     = 1,
    parameter int HOLD_BA     = 1,
    parameter int RD_GAP      = 3,
    parameter int OUT_MODE    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    ndrot_bank_if.slave bus
);
    localparam int INIT_W   = cnt_w(INIT_CYCLES);
    localparam int GAP_W    = cnt_w(RD_GAP);
    localparam int GAP_LOAD = (RD_GAP > 0) ? RD_GAP - 1 : 0;

    logic [NCH-1:0]    a_q, b_q;
    logic              rd_q;
    logic [NCH-1:0]    a_h, b_h;
    logic              rd_h;
    logic [INIT_W-1:0] init_cnt;
    logic              ready;
    logic [GAP_W-1:0]  gap_q;
    logic              viol_rd_q;
    logic [NCH-1:0]    state_vec, q_vec, vab_vec, vba_vec;

    // Edge registers reload the live levels during reset so that whatever
    // level the lines sit at on release is not mistaken for a pulse.
    always_ff @(posedge clk) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        rd_q <= bus.rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (init_cnt != INIT_W'(INIT_CYCLES)) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end
    end

    assign ready = (init_cnt == INIT_W'(INIT_CYCLES));

    assign a_h  = ready ? (bus.a ^ a_q) : '0;
    assign b_h  = ready ? (bus.b ^ b_q) : '0;
    assign rd_h = ready & (bus.rd ^ rd_q);

    // gap_q counts down the cycles left before another rd is legal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q     <= '0;
            viol_rd_q <= 1'b0;
        end else begin
            if (rd_h && (gap_q != '0) && (|state_vec)) viol_rd_q <= 1'b1;
            if (rd_h)               gap_q <= GAP_W'(GAP_LOAD);
            else if (gap_q != '0)   gap_q <= gap_q - GAP_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ndrot_cell #(
            .DELAY   (DELAY),
            .HOLD_AB (HOLD_AB),
            .HOLD_BA (HOLD_BA),
            .OUT_MODE(OUT_MODE)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .a_p    (a_h[i]),
            .b_p    (b_h[i]),
            .rd_p   (rd_h),
            .st     (state_vec[i]),
            .q      (q_vec[i]),
            .viol_ab(vab_vec[i]),
            .viol_ba(vba_vec[i])
        );
    end

    assign bus.q       = q_vec;
    assign bus.state   = state_vec;
    assign bus.ready   = ready;
    assign bus.viol_ab = vab_vec;
    assign bus.viol_ba = vba_vec;
    assign bus.viol_rd = viol_rd_q;

endmodule

// File: tb/tb_ndrot_bank.sv
// -----------------------------------------------------------------------------
// tb_ndrot_bank
// Two banks (toggle-encoded and pulse-encoded q) driven with identical
// stimulus. Readout expectations are queued when rd is driven and compared
// against both q outputs every cycle; scenario tasks check state and flags.
// Cycle k = k-th rising edge after reset release.
// -----------------------------------------------------------------------------
module tb_ndrot_bank;
    localparam int NCH   = 4;
    localparam int DELAY = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0] a_drv = '0;
    logic [NCH-1:0] b_drv = '0;
    logic           rd_drv = 1'b0;

    ndrot_bank_if #(.NCH(NCH)) bus0 ();
    ndrot_bank_if #(.NCH(NCH)) bus1 ();

    assign bus0.a = a_drv;  assign bus0.b = b_drv;  assign bus0.rd = rd_drv;
    assign bus1.a = a_drv;  assign bus1.b = b_drv;  assign bus1.rd = rd_drv;

    ndrot_bank #(.NCH(NCH), .DELAY(DELAY), .INIT_CYCLES(4), .HOLD_AB(1),
                 .HOLD_BA(1), .RD_GAP(3), .OUT_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    ndrot_bank #(.NCH(NCH), .DELAY(DELAY), .INIT_CYCLES(4), .HOLD_AB(1),
                 .HOLD_BA(1), .RD_GAP(3), .OUT_MODE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int vec_cnt = 0;
    int err_cnt = 0;

    int cyc = 0;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    logic [NCH-1:0] exp_q[$];
    int             exp_due_q[$];
    logic [NCH-1:0] exp_tog = '0;
    logic [NCH-1:0] exp_pls;
    bit             mon_en = 1'b0;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            exp_pls = '0;
            if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
                exp_pls = exp_q.pop_front();
                void'(exp_due_q.pop_front());
                exp_tog = exp_tog ^ exp_pls;
            end
            vec_cnt++;
            if (bus0.q !== exp_tog) begin
                err_cnt++;
                $display("FAIL q_toggle cyc %0d: got %b expected %b", cyc, bus0.q, exp_tog);
            end
            vec_cnt++;
            if (bus1.q !== exp_pls) begin
                err_cnt++;
                $display("FAIL q_pulse cyc %0d: got %b expected %b", cyc, bus1.q, exp_pls);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until edge k has just happened.
    task automatic goto(input int k);
        int guard = 0;
        while (cyc < k && guard < 1000) begin
            tick(1);
            guard++;
        end
        if (cyc != k) begin
            err_cnt++;
            $display("FAIL goto: reached cycle %0d expected %0d", cyc, k);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        exp_due_q.delete();
        exp_tog = '0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        mon_en = 1'b0;
        clear_sb();
        // Arbitrary idle levels: release must not turn them into pulses.
        a_drv  = NCH'($urandom_range(0, (1 << NCH) - 1));
        b_drv  = NCH'($urandom_range(0, (1 << NCH) - 1));
        rd_drv = 1'($urandom_range(0, 1));
        tick(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic pulse_a(input logic [NCH-1:0] m);
        a_drv = a_drv ^ m;
    endtask

    task automatic pulse_b(input logic [NCH-1:0] m);
        b_drv = b_drv ^ m;
    endtask

    // exp_mask: channels expected set when this rd is sampled on the next edge.
    task automatic pulse_rd(input logic [NCH-1:0] exp_mask);
        rd_drv = ~rd_drv;
        exp_q.push_back(exp_mask);
        exp_due_q.push_back(cyc + 1 + DELAY);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        mon_en = 1'b0;
        clear_sb();
        a_drv  = 4'b1010;
        b_drv  = 4'b0110;
        rd_drv = 1'b1;
        tick(2);
        vec_cnt++;
        if ({bus0.state, bus0.q, bus0.ready, bus0.viol_ab, bus0.viol_ba, bus0.viol_rd,
             bus1.state, bus1.q, bus1.ready, bus1.viol_ab, bus1.viol_ba, bus1.viol_rd} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b/%b/%b expected all zero",
                     bus0.state, bus0.q, bus1.q);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        goto(3);
        vec_cnt++;
        if ({bus0.ready, bus1.ready} !== 2'b00) begin
            err_cnt++;
            $display("FAIL ready_early: got %b expected 00", {bus0.ready, bus1.ready});
        end
        goto(4);
        vec_cnt++;
        if ({bus0.ready, bus1.ready} !== 2'b11) begin
            err_cnt++;
            $display("FAIL ready_at_4: got %b expected 11", {bus0.ready, bus1.ready});
        end
        goto(8);
        vec_cnt++;
        if ({bus0.state, bus1.state} !== '0) begin
            err_cnt++;
            $display("FAIL release_no_pulse: got %b expected 0", {bus0.state, bus1.state});
        end
    endtask

    task automatic test_set_read();
        do_reset();
        goto(5);  pulse_a(4'b0001);
        goto(6);
        vec_cnt++;
        if ({bus0.state, bus1.state} !== {2{4'b0001}}) begin
            err_cnt++;
            $display("FAIL set_state: got %b expected 0001", bus0.state);
        end
        goto(9);  pulse_rd(4'b0001);
        goto(14);
        vec_cnt++;
        if ({bus0.state, bus0.viol_ab, bus0.viol_ba, bus0.viol_rd} !== {4'b0001, 4'b0, 4'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL read_nondestructive: got state %b vab %b vba %b vrd %b",
                     bus0.state, bus0.viol_ab, bus0.viol_ba, bus0.viol_rd);
        end
    endtask

    task automatic test_not_ready();
        do_reset();
        goto(1);  pulse_a(4'b0010);
        goto(3);
        vec_cnt++;
        if (bus0.state !== 4'b0000) begin
            err_cnt++;
            $display("FAIL not_ready_state: got %b expected 0000", bus0.state);
        end
        goto(9);  pulse_rd(4'b0000);
        goto(13);
        vec_cnt++;
        if ({bus0.state, bus0.viol_ab, bus0.viol_ba, bus0.viol_rd,
             bus1.viol_ab, bus1.viol_ba} !== '0) begin
            err_cnt++;
            $display("FAIL not_ready_flags: got state %b vab %b vba %b vrd %b",
                     bus0.state, bus0.viol_ab, bus0.viol_ba, bus0.viol_rd);
        end
    endtask

    task automatic test_hold_ab();
        do_reset();
        goto(7);  pulse_a(4'b0100);
        goto(8);
        vec_cnt++;
        if (bus0.state !== 4'b0100) begin
            err_cnt++;
            $display("FAIL hold_ab_set: got %b expected 0100", bus0.state);
        end
        pulse_b(4'b0100);
        goto(10);
        vec_cnt++;
        if ({bus0.state, bus0.viol_ab, bus1.viol_ab} !== {4'b0000, 4'b0100, 4'b0100}) begin
            err_cnt++;
            $display("FAIL hold_ab_inside: got state %b vab %b expected 0000 0100",
                     bus0.state, bus0.viol_ab);
        end
        do_reset();
        goto(7);  pulse_a(4'b0100);
        goto(10); pulse_b(4'b0100);
        goto(11);
        vec_cnt++;
        if ({bus0.state, bus0.viol_ab} !== {4'b0000, 4'b0000}) begin
            err_cnt++;
            $display("FAIL hold_ab_outside: got state %b vab %b expected 0000 0000",
                     bus0.state, bus0.viol_ab);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        goto(5);  pulse_a(4'b1000); pulse_b(4'b1000);
        goto(6);
        vec_cnt++;
        if ({bus0.state, bus0.viol_ab, bus0.viol_ba} !== {4'b0000, 4'b1000, 4'b0000}) begin
            err_cnt++;
            $display("FAIL same_cycle_ab: got state %b vab %b vba %b expected 0000 1000 0000",
                     bus0.state, bus0.viol_ab, bus0.viol_ba);
        end
    endtask

    task automatic test_hold_ba();
        do_reset();
        goto(5);  pulse_a(4'b0010);
        goto(7);  pulse_b(4'b0010);
        goto(8);  pulse_a(4'b0010);
        goto(9);
        vec_cnt++;
        if ({bus0.state, bus0.viol_ab, bus0.viol_ba} !== {4'b0010, 4'b0000, 4'b0010}) begin
            err_cnt++;
            $display("FAIL hold_ba_inside: got state %b vab %b vba %b expected 0010 0000 0010",
                     bus0.state, bus0.viol_ab, bus0.viol_ba);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        goto(5);  pulse_a(4'b0001);
        goto(9);  pulse_rd(4'b0001);
        goto(10); pulse_rd(4'b0001);
        goto(11);
        vec_cnt++;
        if ({bus0.viol_rd, bus1.viol_rd} !== 2'b11) begin
            err_cnt++;
            $display("FAIL b2b_viol_rd: got %b expected 11", {bus0.viol_rd, bus1.viol_rd});
        end
        goto(15);
        vec_cnt++;
        if (bus0.state !== 4'b0001) begin
            err_cnt++;
            $display("FAIL b2b_state: got %b expected 0001", bus0.state);
        end

        do_reset();
        goto(9);  pulse_rd(4'b0000);
        goto(10); pulse_rd(4'b0000);
        goto(14);
        vec_cnt++;
        if ({bus0.viol_rd, bus1.viol_rd} !== 2'b00) begin
            err_cnt++;
            $display("FAIL b2b_clr_viol_rd: got %b expected 00", {bus0.viol_rd, bus1.viol_rd});
        end

        do_reset();
        goto(5);  pulse_a(4'b0001);
        goto(9);  pulse_rd(4'b0001);
        goto(12); pulse_rd(4'b0001);
        goto(16);
        vec_cnt++;
        if (bus0.viol_rd !== 1'b0) begin
            err_cnt++;
            $display("FAIL gap_exact_viol_rd: got %b expected 0", bus0.viol_rd);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        goto(5);  pulse_a(4'b0001);
        goto(9);  pulse_rd(4'b0001);
        goto(10);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        clear_sb();
        tick(1);
        vec_cnt++;
        if ({bus0.state, bus0.q, bus0.ready, bus0.viol_ab, bus0.viol_ba, bus0.viol_rd,
             bus1.state, bus1.q, bus1.ready} !== '0) begin
            err_cnt++;
            $display("FAIL midflight_reset: got state %b q %b/%b expected all zero",
                     bus0.state, bus0.q, bus1.q);
        end
        tick(1);
        vec_cnt++;
        if ({bus0.q, bus1.q} !== '0) begin
            err_cnt++;
            $display("FAIL midflight_no_event: got %b/%b expected 0000/0000", bus0.q, bus1.q);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        goto(6);
    endtask

    task automatic test_random_reads();
        logic [NCH-1:0] m;
        logic           exp_vr;
        int             g;
        do_reset();
        m      = NCH'($urandom_range(1, (1 << NCH) - 1));
        exp_vr = 1'b0;
        goto(5);  pulse_a(m);
        goto(6);
        for (int r = 0; r < 6; r++) begin
            g = $urandom_range(1, 4);
            tick(g);
            if (r > 0 && g < 3) exp_vr = 1'b1;
            pulse_rd(m);
        end
        tick(DELAY + 3);
        vec_cnt++;
        if ({bus0.state, bus0.viol_rd, bus1.viol_rd} !== {m, exp_vr, exp_vr}) begin
            err_cnt++;
            $display("FAIL random_reads: got state %b vrd %b/%b expected %b %b",
                     bus0.state, bus0.viol_rd, bus1.viol_rd, m, exp_vr);
        end
    endtask

    initial begin
        test_reset();
        test_set_read();
        test_not_ready();
        test_hold_ab();
        test_same_cycle();
        test_hold_ba();
        test_back_to_back();
        test_reset_midflight();
        for (int k = 0; k < 4; k++) test_random_reads();
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vec_cnt);
        $fatal(1);
    end

endmodule
